// File: rtl/mac_pkg.sv
// Shared request format and request-type constants for the memory access port arbiter.
package mac_pkg;

  localparam logic MAC_RQT_READ  = 1'b0;
  localparam logic MAC_RQT_WRITE = 1'b1;

  localparam int MAC_ORIG_W = 4;

  typedef struct packed {
    logic [31:0]           addr;
    logic [127:0]          dat;
    logic [MAC_ORIG_W-1:0] orig;
    logic                  rqt;
  } mac_request;

  localparam int MAC_REQ_W = $bits(mac_request);

endpackage

// File: rtl/mac_req_fifo.sv
// Request FIFO with wrap-around pointers; a push is refused whenever the FIFO is full.
module mac_req_fifo #(
  parameter int WIDTH = 165,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mac_port_arbiter.sv
// Round-robin arbiter of per-port memory requests into a downstream FIFO,
// with a single holding register routing completions back to their origin port.
module mac_port_arbiter
  import mac_pkg::*;
#(
  parameter int PORT_COUNT  = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_COUNT-1:0]         prt_tx_av,
  output logic [PORT_COUNT-1:0]         prt_tx_re,
  input  logic [PORT_COUNT*32-1:0]      prt_tx_addr,
  input  logic [PORT_COUNT*128-1:0]     prt_tx_dat,
  input  logic [PORT_COUNT-1:0]         prt_tx_rqt,
  output logic [PORT_COUNT-1:0]         prt_rx_av,
  input  logic [PORT_COUNT-1:0]         prt_rx_re,
  output logic [31:0]                   prt_rx_addr,
  output logic [127:0]                  prt_rx_dat,
  output logic                          dn_rp,
  output mac_request                    dn_req,
  input  logic                          dn_ra,
  input  logic                          up_rp,
  input  mac_request                    up_req,
  output logic                          up_ra,
  output logic [$clog2(QUEUE_DEPTH):0]  q_len,
  output logic                          err_bad_orig
);

  localparam int PW  = $clog2(PORT_COUNT);
  localparam int PW1 = PW + 1;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PORT_COUNT-1:0] rd_out_q, rd_out_d;
  logic                  hold_valid_q, hold_valid_d;
  mac_request            hold_req_q, hold_req_d;
  logic                  err_q, err_d;

  logic [PORT_COUNT-1:0] eligible;
  logic                  grant_en;
  logic                  grant_valid;
  logic [PW-1:0]         grant_idx;
  mac_request            push_req;
  mac_request            fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  deliver, capture;

  // Combinational outputs are forced quiet while reset is held low.
  assign grant_en = rst & ~fifo_full;
  assign eligible = prt_tx_av & ~rd_out_q;

  always_comb begin
    logic [PW:0] pos;
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      pos = {1'b0, rr_ptr_q} + PW1'(i);
      if (pos >= PW1'(PORT_COUNT)) pos = pos - PW1'(PORT_COUNT);
      if (!grant_valid && grant_en && eligible[pos[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[PW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid)
      rr_ptr_d = (grant_idx == PW'(PORT_COUNT - 1)) ? '0 : grant_idx + PW'(1);
  end

  assign prt_tx_re     = grant_valid ? (PORT_COUNT'(1) << grant_idx) : '0;
  assign push_req.addr = prt_tx_addr[grant_idx*32 +: 32];
  assign push_req.dat  = prt_tx_dat[grant_idx*128 +: 128];
  assign push_req.orig = MAC_ORIG_W'(grant_idx);
  assign push_req.rqt  = prt_tx_rqt[grant_idx];

  mac_req_fifo #(
    .WIDTH (MAC_REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (grant_valid),
    .wdata (push_req),
    .pop   (dn_rp & dn_ra),
    .rdata (fifo_head),
    .count (q_len),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dn_rp  = ~fifo_empty;
  assign dn_req = dn_rp ? fifo_head : '0;

  // Only the held origin's read strobe can complete a delivery.
  assign prt_rx_av   = hold_valid_q ? (PORT_COUNT'(1) << hold_req_q.orig) : '0;
  assign prt_rx_addr = hold_req_q.addr;
  assign prt_rx_dat  = hold_req_q.dat;
  assign deliver     = |(prt_rx_av & prt_rx_re);
  assign up_ra       = rst & (~hold_valid_q | deliver);
  assign capture     = up_rp & up_ra;

  // The shifted one-hot is zero for an origin beyond PORT_COUNT, so the
  // outstanding-read test also rejects out-of-range origins.
  always_comb begin
    logic [PORT_COUNT-1:0] out_w;
    out_w        = rd_out_q;
    hold_valid_d = hold_valid_q & ~deliver;
    hold_req_d   = hold_req_q;
    err_d        = err_q;
    if (deliver && hold_req_q.rqt == MAC_RQT_READ)
      out_w = out_w & ~prt_rx_av;
    if (capture) begin
      if (|(out_w & (PORT_COUNT'(1) << up_req.orig))) begin
        hold_valid_d = 1'b1;
        hold_req_d   = up_req;
      end else begin
        err_d = 1'b1;
      end
    end
    if (grant_valid && push_req.rqt == MAC_RQT_READ)
      out_w = out_w | prt_tx_re;
    rd_out_d = out_w;
  end

  assign err_bad_orig = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= '0;
      rd_out_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_req_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rd_out_q     <= rd_out_d;
      hold_valid_q <= hold_valid_d;
      hold_req_q   <= hold_req_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mac_port_arbiter.sv
// Randomised and directed checks of mac_port_arbiter against a queue-based reference model.
module tb_mac_port_arbiter;
  import mac_pkg::*;

  localparam int P  = 4;
  localparam int QD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [P-1:0]      prt_tx_av, prt_tx_re, prt_tx_rqt;
  logic [P*32-1:0]   prt_tx_addr;
  logic [P*128-1:0]  prt_tx_dat;
  logic [P-1:0]      prt_rx_av, prt_rx_re;
  logic [31:0]       prt_rx_addr;
  logic [127:0]      prt_rx_dat;
  logic              dn_rp, dn_ra, up_rp, up_ra, err_bad_orig;
  mac_request        dn_req, up_req;
  logic [3:0]        q_len;

  mac_port_arbiter #(.PORT_COUNT(P), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .prt_tx_av(prt_tx_av), .prt_tx_re(prt_tx_re), .prt_tx_addr(prt_tx_addr),
    .prt_tx_dat(prt_tx_dat), .prt_tx_rqt(prt_tx_rqt),
    .prt_rx_av(prt_rx_av), .prt_rx_re(prt_rx_re),
    .prt_rx_addr(prt_rx_addr), .prt_rx_dat(prt_rx_dat),
    .dn_rp(dn_rp), .dn_req(dn_req), .dn_ra(dn_ra),
    .up_rp(up_rp), .up_req(up_req), .up_ra(up_ra),
    .q_len(q_len), .err_bad_orig(err_bad_orig)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: request queue, round-robin pointer, outstanding reads, reply holder.
  mac_request mq[$];
  bit [P-1:0] outM;
  int         rrM;
  bit         holdV;
  mac_request holdM;
  bit         errM;

  // Downstream responder: read requests popped from the DUT come back as completions.
  mac_request rspQ[$];
  bit         rspPresented;

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    rspQ.delete();
    outM  = '0;
    rrM   = 0;
    holdV = 1'b0;
    holdM = '0;
    errM  = 1'b0;
  endtask

  task automatic idleInputs();
    prt_tx_av    = '0;
    prt_tx_rqt   = '0;
    prt_tx_addr  = '0;
    prt_tx_dat   = '0;
    prt_rx_re    = '0;
    dn_ra        = 1'b0;
    up_rp        = 1'b0;
    up_req       = '0;
    rspPresented = 1'b0;
  endtask

  task automatic randomPayload();
    for (int p = 0; p < P; p++) begin
      prt_tx_addr[p*32 +: 32]  = $urandom;
      prt_tx_dat[p*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic driveReturn(input int pct);
    rspPresented = 1'b0;
    up_rp        = 1'b0;
    up_req       = '0;
    if (rspQ.size() > 0 && $urandom_range(99) < pct) begin
      up_rp        = 1'b1;
      up_req       = rspQ[0];
      rspPresented = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs set; checks, clocks, advances the model.
  task automatic applyStimulus();
    int         g;
    bit         deliverM, upRaM;
    bit [P-1:0] expTxRe, expRxAv;
    mac_request r;
    #1;
    g = -1;
    if (mq.size() < QD) begin
      for (int i = 0; i < P; i++) begin
        int p;
        p = (rrM + i) % P;
        if (g < 0 && prt_tx_av[p] && !outM[p]) g = p;
      end
    end
    expTxRe = '0;
    if (g >= 0) expTxRe[g] = 1'b1;
    expRxAv = '0;
    if (holdV) expRxAv[holdM.orig] = 1'b1;
    deliverM = holdV && prt_rx_re[holdM.orig];
    upRaM    = !holdV || deliverM;

    checkOutput("tx_re", prt_tx_re, expTxRe);
    checkOutput("q_len", q_len, mq.size());
    checkOutput("dn_rp", dn_rp, mq.size() != 0);
    if (mq.size() != 0) checkOutput("dn_req", dn_req, mq[0]);
    checkOutput("rx_av", prt_rx_av, expRxAv);
    checkOutput("up_ra", up_ra, upRaM);
    checkOutput("err", err_bad_orig, errM);
    if (holdV) begin
      checkOutput("rx_addr", prt_rx_addr, holdM.addr);
      checkOutput("rx_dat", prt_rx_dat, holdM.dat);
    end

    @(posedge clk);
    if (mq.size() != 0 && dn_ra) begin
      r = mq.pop_front();
      if (r.rqt == MAC_RQT_READ) begin
        r.dat = {$urandom, $urandom, $urandom, $urandom};
        rspQ.push_back(r);
      end
    end
    if (g >= 0) begin
      r.addr = prt_tx_addr[g*32 +: 32];
      r.dat  = prt_tx_dat[g*128 +: 128];
      r.orig = 4'(g);
      r.rqt  = prt_tx_rqt[g];
      mq.push_back(r);
    end
    if (deliverM) begin
      if (holdM.rqt == MAC_RQT_READ) outM[holdM.orig] = 1'b0;
      holdV = 1'b0;
    end
    if (up_rp && upRaM) begin
      if (rspPresented) void'(rspQ.pop_front());
      if (up_req.orig < P && outM[up_req.orig]) begin
        holdV = 1'b1;
        holdM = up_req;
      end else begin
        errM = 1'b1;
      end
    end
    if (g >= 0) begin
      if (prt_tx_rqt[g] == MAC_RQT_READ) outM[g] = 1'b1;
      rrM = (g + 1) % P;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    checkOutput("rst_tx_re", prt_tx_re, 0);
    checkOutput("rst_rx_av", prt_rx_av, 0);
    checkOutput("rst_rx_addr", prt_rx_addr, 0);
    checkOutput("rst_rx_dat", prt_rx_dat, 0);
    checkOutput("rst_dn_rp", dn_rp, 0);
    checkOutput("rst_dn_req", dn_req, 0);
    checkOutput("rst_up_ra", up_ra, 0);
    checkOutput("rst_q_len", q_len, 0);
    checkOutput("rst_err", err_bad_orig, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic randomInputs();
    prt_tx_av  = P'($urandom);
    prt_tx_rqt = P'($urandom);
    randomPayload();
    dn_ra     = ($urandom_range(99) < 70);
    prt_rx_re = P'($urandom);
    driveReturn(70);
    if ($urandom_range(99) < 3) begin
      up_rp        = 1'b1;
      rspPresented = 1'b0;
      up_req.addr  = $urandom;
      up_req.dat   = {$urandom, $urandom, $urandom, $urandom};
      up_req.orig  = 4'($urandom_range(15));
      up_req.rqt   = 1'($urandom);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idleInputs();
    @(negedge clk);
    doReset();

    // Round robin across four reading ports, then blocked until replies drain.
    idleInputs();
    prt_tx_av = '1;
    dn_ra     = 1'b1;
    randomPayload();
    for (int i = 0; i < P; i++) begin
      #1;
      checkOutput("rr_grant", prt_tx_re, P'(1) << i);
      applyStimulus();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("rr_blocked", prt_tx_re, 0);
      applyStimulus();
    end
    prt_tx_av = '0;
    prt_rx_re = '1;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && rspQ.size() == 0 && !holdV) break;
      driveReturn(100);
      applyStimulus();
    end
    checkOutput("rr_drain_qlen", q_len, 0);
    checkOutput("rr_drain_rx_av", prt_rx_av, 0);
    idleInputs();
    prt_tx_av = '1;
    #1;
    checkOutput("rr_unblocked", prt_tx_re, 4'b0001);
    applyStimulus();

    // Full FIFO: ten writes offered with no downstream acceptance.
    doReset();
    idleInputs();
    prt_tx_rqt = '1;
    for (int i = 0; i < 10; i++) begin
      prt_tx_av = P'(1) << (i % P);
      randomPayload();
      applyStimulus();
    end
    checkOutput("full_qlen", q_len, 8);
    checkOutput("full_tx_re", prt_tx_re, 0);
    dn_ra     = 1'b1;
    prt_tx_av = 4'b0001;
    #1;
    checkOutput("full_push_refused", prt_tx_re, 0);
    applyStimulus();
    checkOutput("full_pop_qlen", q_len, 7);

    // Return path: capture, then back-to-back delivery with no bubble.
    doReset();
    idleInputs();
    dn_ra      = 1'b1;
    prt_tx_av  = 4'b0110;
    randomPayload();
    applyStimulus();
    applyStimulus();
    prt_tx_av = '0;
    applyStimulus();
    applyStimulus();
    rspQ.delete();
    up_rp  = 1'b1;
    up_req = '{addr: 32'h100, dat: 128'hAB, orig: 4'd2, rqt: MAC_RQT_READ};
    applyStimulus();
    checkOutput("ret_rx_av", prt_rx_av, 4'b0100);
    checkOutput("ret_rx_addr", prt_rx_addr, 32'h100);
    checkOutput("ret_rx_dat", prt_rx_dat, 128'hAB);
    up_req    = '{addr: 32'h200, dat: 128'hCD, orig: 4'd1, rqt: MAC_RQT_READ};
    prt_rx_re = 4'b0100;
    #1;
    checkOutput("ret_up_ra", up_ra, 1);
    applyStimulus();
    checkOutput("ret_b2b_rx_av", prt_rx_av, 4'b0010);
    checkOutput("ret_b2b_addr", prt_rx_addr, 32'h200);
    up_rp     = 1'b0;
    prt_rx_re = 4'b0010;
    applyStimulus();
    checkOutput("ret_done_rx_av", prt_rx_av, 0);

    // Bad origin: consumed, never delivered, sticky error until reset.
    doReset();
    idleInputs();
    up_rp  = 1'b1;
    up_req = '{addr: 32'h300, dat: 128'h55, orig: 4'd9, rqt: MAC_RQT_READ};
    #1;
    checkOutput("bad_up_ra", up_ra, 1);
    applyStimulus();
    up_rp = 1'b0;
    checkOutput("bad_rx_av", prt_rx_av, 0);
    checkOutput("bad_err", err_bad_orig, 1);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("bad_err_sticky", err_bad_orig, 1);

    // Mid-operation reset with a queued backlog and a held reply.
    doReset();
    idleInputs();
    dn_ra     = 1'b1;
    prt_tx_av = 4'b1000;
    randomPayload();
    applyStimulus();
    prt_tx_av = '0;
    applyStimulus();
    dn_ra = 1'b0;
    driveReturn(100);
    applyStimulus();
    up_rp        = 1'b0;
    rspPresented = 1'b0;
    prt_tx_av    = 4'b0001;
    prt_tx_rqt   = '1;
    for (int i = 0; i < 5; i++) begin
      randomPayload();
      applyStimulus();
    end
    checkOutput("pre_rst_qlen", q_len, 5);
    checkOutput("pre_rst_rx_av", prt_rx_av, 4'b1000);
    prt_tx_av  = '1;
    prt_tx_rqt = '0;
    doReset();
    #1;
    checkOutput("post_rst_grant", prt_tx_re, 4'b0001);
    prt_rx_re = '1;
    for (int i = 0; i < 3; i++) applyStimulus();

    // Randomised traffic, with one reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) doReset();
      randomInputs();
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
